// File: rtl/sram_bank_if.sv
// -----------------------------------------------------------------------------
// sram_bank_if -- request/response bundle for the sram_bank memory.
//
// Request channel  (master -> slave): req_valid, req_wen, req_addr,
//                                     req_wdata, req_be
//                  (slave -> master): req_ready
// Response channel (slave -> master): rsp_valid, rsp_rdata
//                  (master -> slave): rsp_ready
// Status           (slave -> master): busy (initialisation clear running)
//
// The ADDR_WIDTH default comes from `SRAM_ADDR_WIDTH; a fallback value is
// provided when the macro is not supplied by the build.
// -----------------------------------------------------------------------------
`ifndef SRAM_ADDR_WIDTH
`define SRAM_ADDR_WIDTH 10
`endif

interface sram_bank_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = `SRAM_ADDR_WIDTH
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_wen;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [DATA_WIDTH-1:0]     req_wdata;
    logic [DATA_WIDTH/8-1:0]   req_be;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_WIDTH-1:0]     rsp_rdata;
    logic                      busy;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/sram_bank.sv
// -----------------------------------------------------------------------------
// sram_bank -- single-port word memory with byte-masked writes and a
// two-entry in-order read response buffer.
//
// Ports:
//   clk  - sole clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - sram_bank_if.slave: valid/ready request channel (read/write,
//          byte address, write data, byte enables), valid/ready read
//          response channel, and busy status.
//
// Behaviour:
//   - A request is accepted when req_valid && req_ready. req_ready depends
//     only on state, buffer occupancy and rst, never on req_* inputs.
//   - Reads sample the memory at acceptance and land in the response buffer,
//     so data appears the cycle after acceptance. Occupancy is the buffer
//     count; a pop and a push in the same cycle leave it unchanged, which
//     keeps req_ready high for back-to-back reads while rsp_ready is held.
//   - Memory contents are not reset.
//
// Configuration macro SRAM_INIT_CLEAR_EN:
//   defined   - after reset the FSM sits in CLEAR, zeroing one entry per
//               cycle (busy=1, req_ready=0), then enters RUN.
//   undefined - the FSM enters RUN directly after reset, busy is constant 0.
// -----------------------------------------------------------------------------
`ifndef SRAM_ADDR_WIDTH
`define SRAM_ADDR_WIDTH 10
`endif

module sram_bank #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = `SRAM_ADDR_WIDTH
) (
    input  logic        clk,
    input  logic        rst,
    sram_bank_if.slave  bus
);
    localparam int BE_W    = DATA_WIDTH / 8;
    localparam int OFF_W   = $clog2(BE_W);
    localparam int IDX_W   = ADDR_WIDTH - OFF_W;
    localparam int ENTRIES = 1 << IDX_W;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  mem_q [ENTRIES];

    // Two-entry response FIFO
    logic [DATA_WIDTH-1:0]  buf_q [2];
    logic [DATA_WIDTH-1:0]  buf_d [2];
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             cnt_q, cnt_d;

    logic                   req_ready_s;
    logic                   rsp_valid_s;
    logic                   accept_s;
    logic                   rd_acc_s;
    logic                   wr_acc_s;
    logic                   pop_s;
    logic [IDX_W-1:0]       req_idx_s;

    logic                   mem_we_s;
    logic [IDX_W-1:0]       mem_idx_s;
    logic [DATA_WIDTH-1:0]  mem_wdata_s;
    logic [BE_W-1:0]        mem_be_s;

`ifdef SRAM_INIT_CLEAR_EN
    logic [IDX_W-1:0]       clr_idx_q, clr_idx_d;
`endif

    // Handshake qualifiers; rst gates the outputs so they read as idle during reset.
    always_comb begin
        req_ready_s = !rst && (state_q == RUN) && (cnt_q < 2'd2);
        rsp_valid_s = !rst && (cnt_q != 2'd0);
        accept_s    = bus.req_valid && req_ready_s;
        rd_acc_s    = accept_s && !bus.req_wen;
        wr_acc_s    = accept_s && bus.req_wen;
        pop_s       = rsp_valid_s && bus.rsp_ready;
        req_idx_s   = bus.req_addr[ADDR_WIDTH-1:OFF_W];
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_s;
    assign bus.rsp_rdata = rsp_valid_s ? buf_q[rd_ptr_q] : {DATA_WIDTH{1'b0}};
`ifdef SRAM_INIT_CLEAR_EN
    assign bus.busy      = !rst && (state_q == CLEAR);
`else
    assign bus.busy      = 1'b0;
`endif

    // FSM next state: CLEAR walks every entry once, RUN is terminal.
    always_comb begin
        state_d = state_q;
`ifdef SRAM_INIT_CLEAR_EN
        clr_idx_d = clr_idx_q;
`endif
        case (state_q)
            CLEAR: begin
`ifdef SRAM_INIT_CLEAR_EN
                clr_idx_d = clr_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                if (clr_idx_q == {IDX_W{1'b1}}) begin
                    state_d = RUN;
                end else begin
                    state_d = CLEAR;
                end
`else
                state_d = RUN;
`endif
            end
            RUN:     state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // FSM state register; reset restarts the clear sequence from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
`ifdef SRAM_INIT_CLEAR_EN
            state_q   <= CLEAR;
            clr_idx_q <= {IDX_W{1'b0}};
`else
            state_q   <= RUN;
`endif
        end else begin
            state_q   <= state_d;
`ifdef SRAM_INIT_CLEAR_EN
            clr_idx_q <= clr_idx_d;
`endif
        end
    end

    // Memory write-port source: the clear sequence owns the port while in CLEAR.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_idx_s   = req_idx_s;
        mem_wdata_s = bus.req_wdata;
        mem_be_s    = bus.req_be;
`ifdef SRAM_INIT_CLEAR_EN
        if (!rst && (state_q == CLEAR)) begin
            mem_we_s    = 1'b1;
            mem_idx_s   = clr_idx_q;
            mem_wdata_s = {DATA_WIDTH{1'b0}};
            mem_be_s    = {BE_W{1'b1}};
        end else begin
            mem_we_s    = wr_acc_s;
        end
`else
        mem_we_s = wr_acc_s;
`endif
    end

    // Byte-masked memory array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < BE_W; b++) begin
                if (mem_be_s[b]) begin
                    mem_q[mem_idx_s][b*8 +: 8] <= mem_wdata_s[b*8 +: 8];
                end
            end
        end
    end

    // Response FIFO next state: push on read accept, pop on response handshake.
    always_comb begin
        buf_d    = buf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (rd_acc_s) begin
            buf_d[wr_ptr_q] = mem_q[req_idx_s];
            wr_ptr_d        = ~wr_ptr_q;
        end else begin
            wr_ptr_d        = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ~rd_ptr_q;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({rd_acc_s, pop_s})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Response FIFO registers; reset drops buffered and pending responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q[0] <= {DATA_WIDTH{1'b0}};
            buf_q[1] <= {DATA_WIDTH{1'b0}};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            buf_q    <= buf_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: doc/sram_bank.md
SRAM_BANK -- requirements
Module: sram_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: word width in bits, a multiple of 8, minimum 16.
REQ-002 SHALL have parameter ADDR_WIDTH, default `SRAM_ADDR_WIDTH: byte-address width; ENTRIES = 2**(ADDR_WIDTH - log2(DATA_WIDTH/8)).
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  request can be accepted.
REQ-007 SHALL have port req_wen  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored.
REQ-009 SHALL have port req_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port req_be  input  DATA_WIDTH/8  per-byte write enable.
REQ-011 SHALL have port rsp_valid  output  1  read data present.
REQ-012 SHALL have port rsp_ready  input  1  consumer accepts read data.
REQ-013 SHALL have port rsp_rdata  output  DATA_WIDTH  read data; 0 when rsp_valid=0.
REQ-014 SHALL have port busy  output  1  initialisation clear in progress.

Function
REQ-015 A request SHALL be accepted exactly in a cycle with req_valid=1 and req_ready=1; req_ready SHALL not depend combinationally on any req_* input.
REQ-016 An accepted write SHALL update only bytes whose req_be bit is 1 at the addressed entry, visible to any read accepted on a later cycle; no response SHALL be produced; be=0 SHALL leave memory unchanged.
REQ-017 An accepted read SHALL produce its data at the response interface no earlier than the cycle after acceptance; minimum latency 1 cycle when rsp_ready=1.
REQ-018 Responses SHALL be delivered in acceptance order, each once, held stable with rsp_valid=1 until rsp_valid&rsp_ready.
REQ-019 Response buffering SHALL be 2 entries; occupancy = buffered responses + read in flight.
REQ-020 req_ready SHALL be 1 only in state RUN with occupancy < 2 at start of cycle; writes are gated identically.
REQ-021 With rsp_ready held 1, back-to-back reads SHALL sustain one accept per cycle.
REQ-022 A response pop and a new read accept in the same cycle SHALL both take effect; occupancy unchanged.
REQ-023 FSM states: CLEAR, RUN; rsp_* behaviour independent of state once in RUN.

Reset
REQ-024 During rst=1: req_ready=0, rsp_valid=0, rsp_rdata=0, response buffer emptied, in-flight read discarded.
REQ-025 Memory contents SHALL not be altered by reset unless the clear feature is compiled in.
REQ-026 Reset asserted mid-operation or mid-clear SHALL take effect on the next rising edge with the same values as REQ-024.

Configuration
REQ-027 Macro SRAM_INIT_CLEAR_EN: when defined, after rst falls FSM enters CLEAR, writes all-zero to entries 0..ENTRIES-1 one per cycle, busy=1, req_ready=0, then enters RUN with busy=0; reset during CLEAR restarts from entry 0.
REQ-028 When SRAM_INIT_CLEAR_EN is undefined: FSM enters RUN the first cycle after rst falls, busy SHALL be constant 0, and power-up contents are undefined.

Verification
REQ-029 Write addr 0x10 data 0x1122334455667788 be=0xFF, then read 0x10 with rsp_ready=1 -> rsp_valid next cycle, rsp_rdata=0x1122334455667788.
REQ-030 Then write addr 0x10 data 0xAAAAAAAAAAAAAAAA be=0x0F, read 0x17 -> rsp_rdata=0x11223344AAAAAAAA (low bits ignored).
REQ-031 rsp_ready=0, issue 3 reads -> 2 accepted, req_ready=0 after; raise rsp_ready -> 2 responses in order, third read then accepted.
REQ-032 rsp_ready=1, 8 consecutive reads of entries 0..7 -> req_ready stays 1, 8 responses on 8 consecutive cycles.
REQ-033 With SRAM_INIT_CLEAR_EN, ADDR_WIDTH=6 (8 entries): release rst -> busy=1 for 8 cycles, any read then returns 0; pulse rst at clear cycle 4 -> busy=1 again for full 8 cycles.
REQ-034 Assert rst one cycle while a response is pending with rsp_ready=0 -> rsp_valid=0 next cycle, pending response never delivered.
